// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC and fetch sequencer for the instruction ROM.
// Steps, stalls or redirects the PC; stops on the all-ones halt word.
module inst_fetch_ctrl #(
  parameter int A  = 10,
  parameter int W  = 10,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic [W-1:0]  InstIn,
  input  logic          Stall,
  input  logic          BranchAbs,
  input  logic [A-1:0]  Target,
  input  logic          BranchRel,
  input  logic [A-1:0]  Offset,
  output logic [A-1:0]  InstAddress,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] InstCount,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic          done_q, done_d;
  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;

  logic          is_run;
  logic          consume;
  logic          halt_word;
  logic          sel_halt;
  logic          sel_abs;
  logic          sel_rel;
  logic          sel_seq;
  logic [A-1:0]  pc_inc;
  logic [A-1:0]  pc_rel;
  logic [CW-1:0] icnt_inc;
  logic [CW-1:0] ccnt_inc;

  // Decode of the current cycle: what gets consumed and where PC goes.
  always_comb begin
    is_run    = (state_q == RUN);
    consume   = is_run & ~Stall;
    halt_word = (InstIn == '1);
    sel_halt  = halt_word;
    sel_abs   = ~halt_word & BranchAbs;
    sel_rel   = ~halt_word & ~BranchAbs & BranchRel;
    sel_seq   = ~halt_word & ~BranchAbs & ~BranchRel;
    pc_inc    = pc_q + A'(1);
    pc_rel    = pc_q + Offset;
    icnt_inc  = (icnt_q == '1) ? icnt_q : icnt_q + CW'(1);
    ccnt_inc  = (ccnt_q == '1) ? ccnt_q : ccnt_q + CW'(1);
  end

  // Next-state, PC and counter update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    icnt_d  = icnt_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          done_d  = 1'b0;
          icnt_d  = '0;
          ccnt_d  = '0;
        end
      end
      RUN: begin
        ccnt_d = ccnt_inc;
        if (consume) begin
          icnt_d = icnt_inc;
          unique case (1'b1)
            sel_halt: begin
              state_d = HALT;
              done_d  = 1'b1;
            end
            sel_abs: pc_d = Target;
            sel_rel: pc_d = pc_rel;
            sel_seq: pc_d = pc_inc;
            default: pc_d = pc_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      icnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      icnt_q  <= icnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign InstValid   = consume;
  assign Busy        = is_run;
  assign Done        = done_q;
  assign InstCount   = icnt_q;
  assign CycleCount  = ccnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed and random checks of inst_fetch_ctrl
// against a cycle-level behavioural model of the fetch sequencer.
module tb_inst_fetch_ctrl;

  localparam int A  = 10;
  localparam int W  = 10;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  localparam int AMASK = (1 << A) - 1;
  localparam int HALTW = (1 << W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [A-1:0]  start_addr;
  logic [W-1:0]  inst_in;
  logic          stall;
  logic          babs;
  logic [A-1:0]  target;
  logic          brel;
  logic [A-1:0]  offset;
  logic [A-1:0]  inst_address;
  logic          inst_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] inst_count;
  logic [CW-1:0] cycle_count;

  logic [W-1:0]  rom [1 << A];

  int checks;
  int errors;
  int m_mode;
  int m_pc;
  int m_done;
  int m_ic;
  int m_cc;

  inst_fetch_ctrl #(.A(A), .W(W), .CW(CW)) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .Start      (start),
    .StartAddr  (start_addr),
    .InstIn     (inst_in),
    .Stall      (stall),
    .BranchAbs  (babs),
    .Target     (target),
    .BranchRel  (brel),
    .Offset     (offset),
    .InstAddress(inst_address),
    .InstValid  (inst_valid),
    .Busy       (busy),
    .Done       (done),
    .InstCount  (inst_count),
    .CycleCount (cycle_count)
  );

  assign inst_in = rom[inst_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_next();
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_pc   = 0;
      m_done = 0;
      m_ic   = 0;
      m_cc   = 0;
    end else if (m_mode == M_RUN) begin
      m_cc = sat(m_cc);
      if (!stall) begin
        m_ic = sat(m_ic);
        if (int'(rom[m_pc]) == HALTW) begin
          m_mode = M_HALT;
          m_done = 1;
        end else if (babs) begin
          m_pc = int'(target);
        end else if (brel) begin
          m_pc = (m_pc + int'(offset)) & AMASK;
        end else begin
          m_pc = (m_pc + 1) & AMASK;
        end
      end
    end else if (start) begin
      m_mode = M_RUN;
      m_pc   = int'(start_addr);
      m_done = 0;
      m_ic   = 0;
      m_cc   = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("pc", inst_address, m_pc);
    chk("busy", busy, m_mode == M_RUN);
    chk("done", done, m_done);
    chk("valid", inst_valid, (m_mode == M_RUN) && !stall);
    chk("icnt", inst_count, m_ic);
    chk("ccnt", cycle_count, m_cc);
    model_next();
    @(posedge clk);
    #1;
    start = 1'b0;
    stall = 1'b0;
    babs  = 1'b0;
    brel  = 1'b0;
  endtask

  initial begin
    int ic0;
    int cc0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    stall = 1'b0;
    babs = 1'b0;
    target = '0;
    brel = 1'b0;
    offset = '0;
    for (int i = 0; i < (1 << A); i++)
      rom[i] = W'($urandom_range(0, HALTW - 1));

    @(posedge clk);
    #1;
    model_next();
    step();
    step();
    chk("rst_pc", inst_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", inst_count, 0);
    rst_n = 1'b1;

    rom[4] = '1;
    start = 1'b1;
    start_addr = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("seq_addr", inst_address, i);
      step();
    end
    chk("seq_done", done, 1);
    chk("seq_icnt", inst_count, 5);
    chk("seq_ccnt", cycle_count, 5);
    chk("seq_pc", inst_address, 4);
    step();
    chk("seq_hold", inst_address, 4);

    rom[4] = 10'd5;
    start = 1'b1;
    start_addr = 3;
    step();
    babs = 1'b1;
    target = 1;
    step();
    chk("babs", inst_address, 1);
    repeat (4) step();
    chk("pc5", inst_address, 5);
    brel = 1'b1;
    offset = 10'h3FE;
    step();
    chk("brel", inst_address, 3);
    babs = 1'b1;
    target = 9;
    brel = 1'b1;
    offset = 1;
    step();
    chk("abs_wins", inst_address, 9);

    babs = 1'b1;
    target = 2;
    step();
    ic0 = int'(inst_count);
    cc0 = int'(cycle_count);
    repeat (3) begin
      stall = 1'b1;
      step();
    end
    chk("stall_pc", inst_address, 2);
    chk("stall_ic", inst_count, ic0);
    chk("stall_cc", cycle_count, cc0 + 3);

    babs = 1'b1;
    target = 10'h3FF;
    step();
    step();
    chk("wrap", inst_address, 0);

    rom[10] = '1;
    babs = 1'b1;
    target = 10;
    step();
    babs = 1'b1;
    target = 50;
    step();
    chk("halt_pri_pc", inst_address, 10);
    chk("halt_pri_done", done, 1);

    start = 1'b1;
    start_addr = 20;
    step();
    chk("restart_pc", inst_address, 20);
    chk("restart_busy", busy, 1);
    chk("restart_cnt", inst_count, 0);

    babs = 1'b1;
    target = 7;
    step();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    chk("midrst_pc", inst_address, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;

    start = 1'b1;
    start_addr = 100;
    step();
    repeat (70) step();
    chk("sat_icnt", inst_count, CMAX);
    chk("sat_ccnt", cycle_count, CMAX);

    for (int i = 0; i < (1 << A); i++)
      if ($urandom_range(0, 15) == 0) rom[i] = '1;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      start = ($urandom_range(0, 7) == 0);
      start_addr = A'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      babs = ($urandom_range(0, 7) == 0);
      target = A'($urandom);
      brel = ($urandom_range(0, 7) == 0);
      offset = A'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
